// File: rtl/uart_tx.sv
// 8-bit UART transmitter with a one-entry holding buffer and optional parity.
// Frames: start(0), data LSB first, optional parity, stop(1); each bit CLOCKS_PER_BIT cycles.
module uart_tx #(
  parameter int CLOCK_SPEED    = 100_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int CLOCKS_PER_BIT = CLOCK_SPEED / BAUD_RATE,
  parameter int PARITY         = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CPB = (CLOCKS_PER_BIT < 2) ? 2 : CLOCKS_PER_BIT;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic HAS_PAR = (PARITY != 0);
  localparam logic ODD_PAR = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [7:0]    r_buf_data;
  logic          r_buf_full;
  logic          r_ready;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;

  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    w_bit_idx_next;
  logic [7:0]    w_shift_next;
  logic          w_par_next;
  logic [7:0]    w_buf_data_next;
  logic          w_buf_full_next;
  logic          w_tx_next;
  logic          w_busy_next;
  logic          w_done_next;
  logic          w_load;
  logic          w_accept;
  logic          w_bit_end;

  assign w_accept  = tx_valid & r_ready;
  assign w_bit_end = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_load         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (r_buf_full) begin
          w_load       = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_cnt_next     = '0;
          w_bit_idx_next = 3'd0;
          w_state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_next = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          // A buffered byte chains straight into the next start bit.
          if (r_buf_full) begin
            w_load       = 1'b1;
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_load) begin
      w_shift_next = r_buf_data;
    end
    w_par_next = w_load ? ((^r_buf_data) ^ ODD_PAR) : r_par;

    w_buf_data_next = w_accept ? tx_data : r_buf_data;
    w_buf_full_next = w_accept ? 1'b1 : (w_load ? 1'b0 : r_buf_full);

    // Outputs are decoded from the next state so they can be registered.
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
      ST_PARITY: w_tx_next = w_par_next;
      default:   w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != ST_IDLE);
    w_done_next = (w_state_next == ST_STOP) && (w_cnt_next == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'd0;
      r_par      <= 1'b0;
      r_buf_data <= 8'd0;
      r_buf_full <= 1'b0;
      r_ready    <= 1'b1;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_par      <= w_par_next;
      r_buf_data <= w_buf_data_next;
      r_buf_full <= w_buf_full_next;
      r_ready    <= ~w_buf_full_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign tx_ready = r_ready;
  assign tx       = r_tx;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no/even/odd parity), 10 clocks per bit.
module tb_uart_tx;

  logic            clk;
  logic            rst;
  logic [2:0][7:0] data_p;
  logic [2:0]      valid_p;
  logic [2:0]      ready_w;
  logic [2:0]      tx_w;
  logic [2:0]      busy_w;
  logic [2:0]      done_w;

  int n_checks;
  int n_pass;

  logic h_tx    [256];
  logic h_busy  [256];
  logic h_done  [256];
  logic h_ready [256];

  uart_tx #(.CLOCK_SPEED(1_000_000), .BAUD_RATE(100_000), .PARITY(0)) u_p0 (
    .clk(clk), .rst(rst), .tx_data(data_p[0]), .tx_valid(valid_p[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );
  uart_tx #(.CLOCK_SPEED(1_000_000), .BAUD_RATE(100_000), .PARITY(1)) u_p1 (
    .clk(clk), .rst(rst), .tx_data(data_p[1]), .tx_valid(valid_p[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );
  uart_tx #(.CLOCK_SPEED(1_000_000), .BAUD_RATE(100_000), .PARITY(2)) u_p2 (
    .clk(clk), .rst(rst), .tx_data(data_p[2]), .tx_valid(valid_p[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // History index c holds outputs after the edge preceding negedge c.
  // Offers are held until tx_ready is seen high; idle data is scrambled every cycle.
  task automatic run_window(input int s, input int ncyc,
                            input int oc0, input logic [7:0] ob0,
                            input int oc1, input logic [7:0] ob1,
                            input int rc);
    int         pend;
    logic [7:0] pb;
    pend = 0;
    pb   = 8'd0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      h_tx[c]    = tx_w[s];
      h_busy[c]  = busy_w[s];
      h_done[c]  = done_w[s];
      h_ready[c] = ready_w[s];
      if (c == oc0) begin pend = 1; pb = ob0; end
      if (c == oc1) begin pend = 1; pb = ob1; end
      rst = (c == rc);
      if (pend != 0) begin
        valid_p[s] = 1'b1;
        data_p[s]  = pb;
        if (h_ready[c]) pend = 0;
      end else begin
        valid_p[s] = 1'b0;
        data_p[s]  = 8'($urandom);
      end
    end
    @(negedge clk);
    rst        = 1'b0;
    valid_p[s] = 1'b0;
  endtask

  function automatic int count_busy(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (h_busy[i]) n++;
    return n;
  endfunction

  function automatic int count_done(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (h_done[i]) n++;
    return n;
  endfunction

  function automatic int count_ready(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (h_ready[i]) n++;
    return n;
  endfunction

  function automatic int count_low(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (!h_tx[i]) n++;
    return n;
  endfunction

  task automatic check_frame(input string tag, input int st, input logic [7:0] b, input int par);
    int   nbits;
    int   cnt;
    logic expb;
    nbits = (par != 0) ? 11 : 10;
    for (int k = 0; k < nbits; k++) begin
      if (k == 0)                   expb = 1'b0;
      else if (k <= 8)              expb = b[k-1];
      else if (par != 0 && k == 9)  expb = (par == 1) ? (^b) : ~(^b);
      else                          expb = 1'b1;
      cnt = 0;
      for (int j = 0; j < 10; j++) if (h_tx[st + 10*k + j] === expb) cnt++;
      check($sformatf("%s bit%0d cycles", tag, k), cnt, 10);
    end
    check($sformatf("%s busy cycles", tag), count_busy(st, st + 10*nbits - 1), 10*nbits);
    check($sformatf("%s done pulses", tag), count_done(st, st + 10*nbits - 1), 1);
    check($sformatf("%s done last", tag), int'(h_done[st + 10*nbits - 1]), 1);
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    valid_p  = 3'b000;
    data_p   = '0;
    n_checks = 0;
    n_pass   = 0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst tx%0d", s),    int'(tx_w[s]),    1);
      check($sformatf("rst busy%0d", s),  int'(busy_w[s]),  0);
      check($sformatf("rst done%0d", s),  int'(done_w[s]),  0);
      check($sformatf("rst ready%0d", s), int'(ready_w[s]), 1);
    end
    rst = 1'b0;
    $display("reset checks done");

    // 0xA5, no parity, from idle
    run_window(0, 130, 2, 8'hA5, -1, 8'h00, -1);
    check_frame("a5", 4, 8'hA5, 0);
    check("a5 tx idle before start", int'(h_tx[3]), 1);
    check("a5 ready after accept", int'(h_ready[3]), 0);
    check("a5 ready at start", int'(h_ready[4]), 1);
    check("a5 busy before start", int'(h_busy[3]), 0);
    check("a5 busy after stop", int'(h_busy[104]), 0);
    check("a5 tx after stop", int'(h_tx[104]), 1);
    check("a5 total busy", count_busy(0, 129), 100);
    check("a5 total done", count_done(0, 129), 1);
    $display("frame 0xA5 parity none done");

    // 0x07 even parity -> parity bit 1
    run_window(1, 140, 2, 8'h07, -1, 8'h00, -1);
    check_frame("even07", 4, 8'h07, 1);
    check("even07 parity bit", int'(h_tx[94]), 1);
    check("even07 total busy", count_busy(0, 139), 110);
    $display("frame 0x07 parity even done");

    // 0x07 odd parity -> parity bit 0
    run_window(2, 140, 2, 8'h07, -1, 8'h00, -1);
    check_frame("odd07", 4, 8'h07, 2);
    check("odd07 parity bit", int'(h_tx[94]), 0);
    check("odd07 total busy", count_busy(0, 139), 110);
    $display("frame 0x07 parity odd done");

    // 0x55 then 0xAA accepted mid-frame: no gap between frames
    run_window(0, 230, 2, 8'h55, 30, 8'hAA, -1);
    check_frame("b2b55", 4, 8'h55, 0);
    check_frame("b2bAA", 104, 8'hAA, 0);
    check("b2b ready before 2nd offer", int'(h_ready[30]), 1);
    check("b2b ready low while buffered", count_ready(31, 103), 0);
    check("b2b ready at 2nd start", int'(h_ready[104]), 1);
    check("b2b total busy", count_busy(0, 229), 200);
    check("b2b total done", count_done(0, 229), 2);
    check("b2b tx idle after", int'(h_tx[204]), 1);
    $display("back-to-back 0x55/0xAA done");

    // 0x34 offered while the buffer is full: held until tx_ready rises
    run_window(0, 240, 2, 8'h12, 3, 8'h34, -1);
    check("hold ready low", int'(h_ready[3]), 0);
    check_frame("hold12", 4, 8'h12, 0);
    check_frame("hold34", 104, 8'h34, 0);
    check("hold total done", count_done(0, 239), 2);
    check("hold no extra frame", count_low(204, 239), 0);
    $display("held-valid 0x12/0x34 done");

    // Reset during data bit 3 of 0xF0; a byte offered with reset is refused
    run_window(0, 120, 2, 8'hF0, 48, 8'h99, 48);
    check("abort in bit3", int'(h_tx[48]), 0);
    check("abort tx", int'(h_tx[49]), 1);
    check("abort busy", int'(h_busy[49]), 0);
    check("abort ready", int'(h_ready[49]), 1);
    check("abort no done", count_done(0, 119), 0);
    check("abort line idle", count_low(49, 119), 0);
    $display("reset abort done");

    run_window(0, 120, 2, 8'h3C, -1, 8'h00, -1);
    check_frame("after3C", 4, 8'h3C, 0);
    $display("frame 0x3C after reset done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter CLOCK_SPEED, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 9600, meaning the serial bit rate.
REQ-003 The module SHALL have parameter CLOCKS_PER_BIT, default CLOCK_SPEED / BAUD_RATE, meaning the clk cycles per serial bit (integer division, minimum 2).
REQ-004 The module SHALL have parameter PARITY, default 0, meaning the parity mode: 0 = none, 1 = even, 2 = odd.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port tx_data, input, 8 bits: the byte to transmit.
REQ-008 The module SHALL have port tx_valid, input, 1 bit: tx_data is offered.
REQ-009 The module SHALL have port tx_ready, output, 1 bit: the module can accept a byte.
REQ-010 The module SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-011 The module SHALL have port tx_busy, output, 1 bit: a frame is on the line.
REQ-012 The module SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-013 A byte SHALL be accepted on any rising edge where tx_valid=1 and tx_ready=1 and rst=0; tx_data SHALL be sampled at that edge only.
REQ-014 The block SHALL contain a one-entry holding buffer; tx_ready SHALL equal buffer-empty and SHALL be registered.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-016 IDLE with buffer full: the next edge SHALL move the byte to the shift register, empty the buffer and enter START; tx SHALL go low in that same cycle.
REQ-017 Accept while IDLE with empty buffer: tx SHALL go low on the cycle after the accepting edge (one-cycle latency).
REQ-018 Every bit (start, 8 data, parity, stop) SHALL hold tx constant for exactly CLOCKS_PER_BIT cycles, counted by a bit-period counter cleared on each state entry.
REQ-019 START SHALL drive 0, then DATA.
REQ-020 DATA SHALL drive bits LSB first (bit 0..7), then PARITY or STOP.
REQ-021 PARITY SHALL drive XOR of the 8 bits (even) or its inverse (odd).
REQ-022 STOP SHALL drive 1.
REQ-023 tx_done SHALL be 1 during the final cycle of STOP only.
REQ-024 End of STOP with buffer full: START SHALL begin on the very next cycle with no idle gap, and the buffer SHALL empty at that edge.
REQ-025 End of STOP with buffer empty: the module SHALL return to IDLE with tx=1.
REQ-026 A new byte MAY be accepted during any state while the buffer is empty, including the cycle the buffer empties.
REQ-027 tx_busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-028 The frame length SHALL be 10 bit periods (PARITY=0) or 11 bit periods.
REQ-029 tx_valid deasserting or tx_data changing mid-frame SHALL NOT affect the frame in flight.
REQ-030 tx SHALL be driven from a register (glitch-free).

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE, counters 0, buffer empty, tx=1, tx_busy=0, tx_done=0 and tx_ready=1 after that edge, aborting any frame in progress.
REQ-032 No byte SHALL be accepted at an edge where rst=1.

Verification (CLOCK_SPEED=1_000_000, BAUD_RATE=100_000, CLOCKS_PER_BIT=10)
REQ-033 PARITY=0, send 0xA5 from idle -> tx low 10 cycles; then 1,0,1,0,0,1,0,1 at 10 cycles each; stop high 10 cycles; tx_done pulses in cycle 100 of the frame.
REQ-034 PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; both frames are 110 cycles.
REQ-035 Back-to-back 0x55 then 0xAA, second accepted mid-frame -> tx_ready drops until the second frame starts; the second start bit follows the first stop bit with zero gap; total 200 cycles busy.
REQ-036 tx_valid held high with the buffer full -> no acceptance until tx_ready rises; the byte is neither lost nor duplicated.
REQ-037 rst asserted during DATA bit 3 -> tx=1 and tx_busy=0 the next cycle, tx_done never pulses, and a new byte is then sent correctly.
REQ-038 tx_data changed every cycle during a frame -> the transmitted bits match the value sampled at acceptance.
